exu_alu_seq: RTL and testbench



---
 rtl/exu_pkg.sv | 42 ++++
 rtl/exu_shifter.sv | 78 +++++++
 rtl/exu_alu_seq.sv | 159 +++++++++++++++
 tb/tb_exu_alu_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// Shared definitions for the exu_* execution units: op codes, sequencer states
// and the immediate sign-extension helper.
package exu_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLT  = 4'd2,
      OP_SLTU = 4'd3,
      OP_XOR  = 4'd4,
      OP_OR   = 4'd5,
      OP_AND  = 4'd6,
      OP_SLL  = 4'd7,
      OP_SRL  = 4'd8,
      OP_SRA  = 4'd9
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_CAPTURE,
      ST_EXEC,
      ST_WRITE
   } state_e;

   typedef enum logic [1:0] {
      SH_SLL,
      SH_SRL,
      SH_SRA
   } shift_e;

   // Replicates bit (width-1) of value into all higher bits; callers truncate to XLEN (<= 64).
   function automatic logic [63:0] sext(input logic [63:0] value, input int unsigned width);
      logic [63:0] shifted;
      shifted = value << (64 - width);
      return $signed(shifted) >>> (64 - width);
   endfunction

endpackage

// File: rtl/exu_shifter.sv
// Shift unit for exu_alu_seq: single-cycle barrel shifter, or a 1-bit-per-cycle
// iterative shifter that finishes in max(shamt,1) cycles counting the start cycle.
module exu_shifter
   import exu_pkg::*;
#(
   parameter int XLEN         = XLEN_DEFAULT,
   parameter int SHIFT_SERIAL = 0,
   parameter int SHW          = $clog2(XLEN)
) (
   input  logic            hclk,
   input  logic            hrstn,
   input  logic            start,
   input  shift_e          kind,
   input  logic [XLEN-1:0] operand,
   input  logic [SHW-1:0]  shamt,
   output logic [XLEN-1:0] result,
   output logic            busy,
   output logic            done
);

   logic [XLEN-1:0] acc_q;
   logic [SHW-1:0]  cnt_q;
   logic            busy_q;
   logic [XLEN-1:0] serial_src;
   logic [XLEN-1:0] serial_step;

   // The start cycle already performs the first 1-bit step, so cnt_q counts the steps still owed.
   always_comb begin
      serial_src  = busy_q ? acc_q : operand;
      serial_step = serial_src;
      case (kind)
         SH_SLL:  serial_step = {serial_src[XLEN-2:0], 1'b0};
         SH_SRL:  serial_step = {1'b0, serial_src[XLEN-1:1]};
         default: serial_step = {serial_src[XLEN-1], serial_src[XLEN-1:1]};
      endcase

      busy   = 1'b0;
      done   = 1'b0;
      result = operand;
      if (SHIFT_SERIAL != 0) begin
         busy = busy_q;
         if (busy_q) begin
            done   = (cnt_q == SHW'(1));
            result = serial_step;
         end else begin
            done   = start && (shamt <= SHW'(1));
            result = (shamt == '0) ? operand : serial_step;
         end
      end else begin
         done = start;
         case (kind)
            SH_SLL:  result = operand << shamt;
            SH_SRL:  result = operand >> shamt;
            default: result = XLEN'($signed(operand) >>> shamt);
         endcase
      end
   end

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         busy_q <= 1'b0;
         acc_q  <= '0;
         cnt_q  <= '0;
      end else if (busy_q) begin
         if (cnt_q == SHW'(1)) begin
            busy_q <= 1'b0;
         end else begin
            acc_q <= serial_step;
            cnt_q <= cnt_q - SHW'(1);
         end
      end else if ((SHIFT_SERIAL != 0) && start && (shamt > SHW'(1))) begin
         busy_q <= 1'b1;
         acc_q  <= serial_step;
         cnt_q  <= shamt - SHW'(1);
      end
   end

endmodule

// File: rtl/exu_alu_seq.sv
// Sequenced register/immediate ALU unit: reads operands over the shared tri-state
// regfile bus, executes one RV32I-style ALU op and writes the result back.
module exu_alu_seq
   import exu_pkg::*;
#(
   parameter int XLEN         = XLEN_DEFAULT,
   parameter int IMM_W        = 12,
   parameter int SHIFT_SERIAL = 0
) (
   input  logic             hclk,
   input  logic             hrstn,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic             use_imm,
   input  logic [IMM_W-1:0] imm,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   output logic             busy,
   output logic             done,
   output logic             err,
   inout  wire  [4:0]       reg_raddr_1,
   inout  wire  [4:0]       reg_raddr_2,
   inout  wire              reg_ren_1,
   inout  wire              reg_ren_2,
   input  logic [XLEN-1:0]  reg_rdata_1,
   input  logic [XLEN-1:0]  reg_rdata_2,
   inout  wire  [4:0]       reg_waddr,
   inout  wire              reg_wen,
   inout  wire  [XLEN-1:0]  reg_wdata
);

   localparam int SHW = $clog2(XLEN);

   state_e          state_q, state_d;
   logic [3:0]      op_q;
   logic            use_imm_q;
   logic [IMM_W-1:0] imm_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] opa_q, opb_q, imm_sext;
   logic [XLEN-1:0] alu_res, ex_res, sh_res;
   logic            accept, illegal, is_shift, sh_start, sh_busy, sh_done, ex_done, wr_go;
   shift_e          sh_kind;

   logic            ren_1_q, ren_2_q, wen_q;
   logic [4:0]      raddr_1_q, raddr_2_q, waddr_q;
   logic [XLEN-1:0] wdata_q;

   assign accept   = (state_q == ST_IDLE) && start;
   assign imm_sext = XLEN'(sext(64'(imm_q), IMM_W));
   assign illegal  = (op_q > 4'd9) || ((op_q == OP_SUB) && use_imm_q);
   assign is_shift = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);
   assign sh_kind  = (op_q == OP_SRA) ? SH_SRA : ((op_q == OP_SRL) ? SH_SRL : SH_SLL);
   assign sh_start = (state_q == ST_EXEC) && is_shift && !sh_busy;
   assign ex_done  = is_shift ? sh_done : 1'b1;
   assign ex_res   = is_shift ? sh_res : alu_res;
   // Illegal ops and rd==0 still run the full sequence but never assert wen.
   assign wr_go    = (state_q == ST_EXEC) && ex_done && !illegal && (rd_q != 5'd0);

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_WRITE);
   assign err  = done && illegal;

   exu_shifter #(
      .XLEN         (XLEN),
      .SHIFT_SERIAL (SHIFT_SERIAL),
      .SHW          (SHW)
   ) u_shifter (
      .hclk    (hclk),
      .hrstn   (hrstn),
      .start   (sh_start),
      .kind    (sh_kind),
      .operand (opa_q),
      .shamt   (opb_q[SHW-1:0]),
      .result  (sh_res),
      .busy    (sh_busy),
      .done    (sh_done)
   );

   always_comb begin
      alu_res = '0;
      case (op_q)
         OP_ADD:  alu_res = opa_q + opb_q;
         OP_SUB:  alu_res = opa_q - opb_q;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (opa_q < opb_q)};
         OP_XOR:  alu_res = opa_q ^ opb_q;
         OP_OR:   alu_res = opa_q | opb_q;
         OP_AND:  alu_res = opa_q & opb_q;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_READ;
         ST_READ:    state_d = ST_WAIT;
         ST_WAIT:    state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_EXEC;
         ST_EXEC:    if (ex_done) state_d = ST_WRITE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         use_imm_q <= 1'b0;
         imm_q     <= '0;
         rd_q      <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q      <= op;
            use_imm_q <= use_imm;
            imm_q     <= imm;
            rd_q      <= rd;
         end
         if (state_q == ST_CAPTURE) begin
            opa_q <= reg_rdata_1;
            opb_q <= use_imm_q ? imm_sext : reg_rdata_2;
         end
      end
   end

   // Bus drivers are registered one edge ahead so READ/WRITE cycles see them from the clock edge.
   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         ren_1_q   <= 1'b0;
         ren_2_q   <= 1'b0;
         raddr_1_q <= '0;
         raddr_2_q <= '0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         ren_1_q   <= accept;
         ren_2_q   <= accept && !use_imm;
         raddr_1_q <= accept ? rs1 : 5'd0;
         raddr_2_q <= (accept && !use_imm) ? rs2 : 5'd0;
         wen_q     <= wr_go;
         waddr_q   <= wr_go ? rd_q : 5'd0;
         wdata_q   <= wr_go ? ex_res : '0;
      end
   end

   assign reg_ren_1   = ren_1_q ? 1'b1 : 1'bz;
   assign reg_raddr_1 = ren_1_q ? raddr_1_q : 5'bz;
   assign reg_ren_2   = ren_2_q ? 1'b1 : 1'bz;
   assign reg_raddr_2 = ren_2_q ? raddr_2_q : 5'bz;
   assign reg_wen     = wen_q ? 1'b1 : 1'bz;
   assign reg_waddr   = wen_q ? waddr_q : 5'bz;
   assign reg_wdata   = wen_q ? wdata_q : {XLEN{1'bz}};

endmodule

// File: tb/tb_exu_alu_seq.sv
// Scoreboard bench for exu_alu_seq: a barrel-shift and a serial-shift instance
// share stimulus; a monitor checks every done pulse against queued expectations.
`timescale 1ns/1ps
module tb_exu_alu_seq;
   import exu_pkg::*;

   localparam int XLEN  = 32;
   localparam int IMM_W = 12;

   typedef struct {
      string           name;
      logic            wen;
      logic [4:0]      waddr;
      logic [XLEN-1:0] wdata;
      logic            err;
      int              lat;
      int              t0;
   } exp_t;

   logic             hclk = 1'b0;
   logic             hrstn = 1'b0;
   logic             start_b, start_s;
   logic [3:0]       op;
   logic             use_imm;
   logic [IMM_W-1:0] imm;
   logic [4:0]       rd, rs1, rs2;

   logic busy_b, done_b, err_b, busy_s, done_s, err_s;
   wire  [4:0]      raddr_1_b, raddr_2_b, waddr_b, raddr_1_s, raddr_2_s, waddr_s;
   wire             ren_1_b, ren_2_b, wen_b, ren_1_s, ren_2_s, wen_s;
   wire  [XLEN-1:0] wdata_b, wdata_s;
   logic [XLEN-1:0] rdata_1_b, rdata_2_b, rdata_1_s, rdata_2_s;

   logic [XLEN-1:0] regs [32];
   exp_t q_b[$];
   exp_t q_s[$];
   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;
   int dones_b = 0, dones_s = 0;
   int ren1_b = 0, ren2_b = 0, ren1_s = 0, ren2_s = 0;

   // Contending pull-downs: enables read 0 whenever the unit releases them.
   pulldown pd_ren1_b (ren_1_b);
   pulldown pd_ren2_b (ren_2_b);
   pulldown pd_wen_b  (wen_b);
   pulldown pd_ren1_s (ren_1_s);
   pulldown pd_ren2_s (ren_2_s);
   pulldown pd_wen_s  (wen_s);

   exu_alu_seq #(.XLEN(XLEN), .IMM_W(IMM_W), .SHIFT_SERIAL(0)) dut_b (
      .hclk(hclk), .hrstn(hrstn), .start(start_b), .op(op), .use_imm(use_imm), .imm(imm),
      .rd(rd), .rs1(rs1), .rs2(rs2), .busy(busy_b), .done(done_b), .err(err_b),
      .reg_raddr_1(raddr_1_b), .reg_raddr_2(raddr_2_b), .reg_ren_1(ren_1_b), .reg_ren_2(ren_2_b),
      .reg_rdata_1(rdata_1_b), .reg_rdata_2(rdata_2_b), .reg_waddr(waddr_b), .reg_wen(wen_b),
      .reg_wdata(wdata_b)
   );

   exu_alu_seq #(.XLEN(XLEN), .IMM_W(IMM_W), .SHIFT_SERIAL(1)) dut_s (
      .hclk(hclk), .hrstn(hrstn), .start(start_s), .op(op), .use_imm(use_imm), .imm(imm),
      .rd(rd), .rs1(rs1), .rs2(rs2), .busy(busy_s), .done(done_s), .err(err_s),
      .reg_raddr_1(raddr_1_s), .reg_raddr_2(raddr_2_s), .reg_ren_1(ren_1_s), .reg_ren_2(ren_2_s),
      .reg_rdata_1(rdata_1_s), .reg_rdata_2(rdata_2_s), .reg_waddr(waddr_s), .reg_wen(wen_s),
      .reg_wdata(wdata_s)
   );

   always #5 hclk = ~hclk;

   always @(posedge hclk) cyc <= cyc + 1;

   // Regfile model: data returns the cycle after the enable and holds until the next read.
   always @(posedge hclk) begin
      if (ren_1_b === 1'b1) rdata_1_b <= regs[raddr_1_b];
      if (ren_2_b === 1'b1) rdata_2_b <= regs[raddr_2_b];
      if (ren_1_s === 1'b1) rdata_1_s <= regs[raddr_1_s];
      if (ren_2_s === 1'b1) rdata_2_s <= regs[raddr_2_s];
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
   endtask

   task automatic monitorDut(input logic ser, input logic dn, input logic er, input logic we,
                             input logic [4:0] wa, input logic [XLEN-1:0] wd);
      exp_t  e;
      string tag;
      tag = ser ? "ser" : "bar";
      if (dn === 1'b1) begin
         if (ser) dones_s++; else dones_b++;
         if ((ser && q_s.size() == 0) || (!ser && q_b.size() == 0)) begin
            checkOutput({tag, " unexpected done"}, 64'(dn), 64'(0));
         end else begin
            if (ser) e = q_s.pop_front(); else e = q_b.pop_front();
            checkOutput({tag, " ", e.name, " err"}, 64'(er), 64'(e.err));
            checkOutput({tag, " ", e.name, " wen"}, 64'(we), 64'(e.wen));
            if (e.wen) begin
               checkOutput({tag, " ", e.name, " waddr"}, 64'(wa), 64'(e.waddr));
               checkOutput({tag, " ", e.name, " wdata"}, 64'(wd), 64'(e.wdata));
            end
            checkOutput({tag, " ", e.name, " latency"}, 64'(cyc - e.t0), 64'(e.lat));
         end
      end else begin
         checkOutput({tag, " wen outside WRITE"}, 64'(we), 64'(0));
      end
   endtask

   always @(negedge hclk) begin
      if (ren_1_b === 1'b1) ren1_b++;
      if (ren_2_b === 1'b1) ren2_b++;
      if (ren_1_s === 1'b1) ren1_s++;
      if (ren_2_s === 1'b1) ren2_s++;
      monitorDut(1'b0, done_b, err_b, wen_b, waddr_b, wdata_b);
      monitorDut(1'b1, done_s, err_s, wen_s, waddr_s, wdata_s);
   end

   // Issues one op on the chosen instance, scrambles the inputs afterwards, waits for completion.
   task automatic applyStimulus(input logic ser, input string name, input logic [3:0] o,
                                input logic ui, input logic [IMM_W-1:0] im,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic ew, input logic [XLEN-1:0] ewd, input logic ee,
                                input int elat, input bit restart);
      exp_t e;
      int   n, d0, r1_0, r2_0;
      @(negedge hclk);
      d0   = ser ? dones_s : dones_b;
      r1_0 = ser ? ren1_s : ren1_b;
      r2_0 = ser ? ren2_s : ren2_b;
      op = o; use_imm = ui; imm = im; rd = d; rs1 = s1; rs2 = s2;
      e.name = name; e.wen = ew; e.waddr = d; e.wdata = ewd; e.err = ee; e.lat = elat; e.t0 = cyc;
      if (ser) begin q_s.push_back(e); start_s = 1'b1; end
      else begin q_b.push_back(e); start_b = 1'b1; end
      @(negedge hclk);
      start_b = 1'b0; start_s = 1'b0;
      op = 4'd1; use_imm = ~ui; imm = ~im; rd = 5'd31; rs1 = 5'd30; rs2 = 5'd29;
      checkOutput({name, " busy"}, 64'(ser ? busy_s : busy_b), 64'(1));
      if (restart) begin
         @(negedge hclk);
         op = 4'd0; use_imm = 1'b1; imm = 12'h7; rd = 5'd12;
         if (ser) start_s = 1'b1; else start_b = 1'b1;
         @(negedge hclk);
         start_b = 1'b0; start_s = 1'b0;
      end
      n = 0;
      while ((q_b.size() + q_s.size()) != 0 && n < 60) begin
         @(posedge hclk);
         n++;
      end
      checkOutput({name, " completes in budget"}, 64'(q_b.size() + q_s.size()), 64'(0));
      q_b.delete(); q_s.delete();
      if (restart) repeat (10) @(posedge hclk);
      checkOutput({name, " done count"}, 64'((ser ? dones_s : dones_b) - d0), 64'(1));
      checkOutput({name, " ren_1 cycles"}, 64'((ser ? ren1_s : ren1_b) - r1_0), 64'(1));
      checkOutput({name, " ren_2 cycles"}, 64'((ser ? ren2_s : ren2_b) - r2_0), 64'(!ui));
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int d0b, d0s;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      regs[1] = 32'd5;
      regs[2] = 32'd1;
      start_b = 1'b0; start_s = 1'b0; op = '0; use_imm = 1'b0; imm = '0;
      rd = '0; rs1 = '0; rs2 = '0;
      hrstn = 1'b0;
      repeat (2) @(negedge hclk);
      checkOutput("reset busy", 64'(busy_b), 64'(0));
      checkOutput("reset done", 64'(done_b), 64'(0));
      checkOutput("reset err", 64'(err_b), 64'(0));
      checkOutput("reset ren_1", 64'(ren_1_b), 64'(0));
      checkOutput("reset wen", 64'(wen_s), 64'(0));
      hrstn = 1'b1;

      applyStimulus(0, "ADDI -1",    4'd0, 1, 12'hFFF, 5'd3, 5'd1, 5'd9, 1, 32'h4,        0, 5, 0);
      applyStimulus(0, "XORI",       4'd4, 1, 12'hFFF, 5'd7, 5'd1, 5'd0, 1, 32'hFFFFFFFA, 0, 5, 0);
      applyStimulus(0, "ORI",        4'd5, 1, 12'h0F0, 5'd7, 5'd1, 5'd0, 1, 32'hF5,       0, 5, 0);
      applyStimulus(0, "ANDI",       4'd6, 1, 12'h003, 5'd7, 5'd1, 5'd0, 1, 32'h1,        0, 5, 0);
      applyStimulus(0, "ADD rs1=rd", 4'd0, 0, 12'h000, 5'd1, 5'd1, 5'd2, 1, 32'h6,        0, 5, 0);

      regs[1] = 32'h80000000;
      applyStimulus(0, "SUB",        4'd1, 0, 12'h000, 5'd4, 5'd1, 5'd2, 1, 32'h7FFFFFFF, 0, 5, 0);
      applyStimulus(0, "SLT",        4'd2, 0, 12'h000, 5'd5, 5'd1, 5'd2, 1, 32'h1,        0, 5, 0);
      applyStimulus(0, "SLTU",       4'd3, 0, 12'h000, 5'd5, 5'd1, 5'd2, 1, 32'h0,        0, 5, 0);
      applyStimulus(0, "SLTIU -1",   4'd3, 1, 12'hFFF, 5'd5, 5'd1, 5'd0, 1, 32'h1,        0, 5, 0);
      applyStimulus(0, "SRL reg",    4'd8, 0, 12'h000, 5'd6, 5'd1, 5'd2, 1, 32'h40000000, 0, 5, 0);

      regs[1] = 32'hF0000000;
      applyStimulus(0, "SRAI 4 bar", 4'd9, 1, 12'h004, 5'd6, 5'd1, 5'd0, 1, 32'hFF000000, 0, 5, 0);
      applyStimulus(1, "SRAI 4 ser", 4'd9, 1, 12'h004, 5'd6, 5'd1, 5'd0, 1, 32'hFF000000, 0, 8, 0);
      applyStimulus(1, "SRAI 0 ser", 4'd9, 1, 12'h000, 5'd6, 5'd1, 5'd0, 1, 32'hF0000000, 0, 5, 0);
      applyStimulus(1, "SLLI 1 ser", 4'd7, 1, 12'h001, 5'd6, 5'd1, 5'd0, 1, 32'hE0000000, 0, 5, 0);
      applyStimulus(1, "SRLI 31 ser",4'd8, 1, 12'h01F, 5'd6, 5'd1, 5'd0, 1, 32'h1,        0, 35, 0);
      applyStimulus(0, "ADDI rd=0",  4'd0, 1, 12'h001, 5'd0, 5'd1, 5'd0, 0, 32'h0,        0, 5, 0);
      applyStimulus(0, "op 12",      4'd12, 0, 12'h000, 5'd6, 5'd1, 5'd2, 0, 32'h0,       1, 5, 0);
      applyStimulus(0, "SUB imm",    4'd1, 1, 12'h001, 5'd6, 5'd1, 5'd0, 0, 32'h0,        1, 5, 0);
      applyStimulus(0, "start busy", 4'd0, 1, 12'h001, 5'd8, 5'd1, 5'd0, 1, 32'hF0000001, 0, 5, 1);

      // Abort: serial instance in a long EXEC, barrel instance in READ, when reset hits.
      @(negedge hclk);
      op = 4'd7; use_imm = 1'b1; imm = 12'h008; rd = 5'd10; rs1 = 5'd1; rs2 = 5'd2;
      start_s = 1'b1;
      @(negedge hclk);
      start_s = 1'b0;
      repeat (4) @(negedge hclk);
      op = 4'd0; use_imm = 1'b0; rd = 5'd11;
      start_b = 1'b1;
      @(negedge hclk);
      start_b = 1'b0;
      checkOutput("pre-reset bar ren_1", 64'(ren_1_b), 64'(1));
      checkOutput("pre-reset ser busy", 64'(busy_s), 64'(1));
      d0b = dones_b; d0s = dones_s;
      hrstn = 1'b0;
      #1;
      checkOutput("abort ser busy", 64'(busy_s), 64'(0));
      checkOutput("abort bar busy", 64'(busy_b), 64'(0));
      checkOutput("abort bar ren_1", 64'(ren_1_b), 64'(0));
      checkOutput("abort bar ren_2", 64'(ren_2_b), 64'(0));
      checkOutput("abort ser wen", 64'(wen_s), 64'(0));
      @(negedge hclk);
      hrstn = 1'b1;
      repeat (15) @(posedge hclk);
      checkOutput("abort bar no done", 64'(dones_b - d0b), 64'(0));
      checkOutput("abort ser no done", 64'(dones_s - d0s), 64'(0));

      applyStimulus(0, "ADDI post-rst", 4'd0, 1, 12'h002, 5'd9, 5'd1, 5'd0, 1, 32'hF0000002, 0, 5, 0);
      applyStimulus(1, "SRA reg post-rst", 4'd9, 0, 12'h000, 5'd9, 5'd1, 5'd2, 1, 32'hF8000000, 0, 5, 0);

      repeat (3) @(negedge hclk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
